// File: rtl/cmp_pkg.sv
// Shared types and constants for the hierarchical magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } cmp_res_e;

  localparam int CMP_CELL_W = 2;

endpackage

// File: rtl/comparator_2bit.sv
// Combinational 2-bit compare cell: eq/gt/lt of a against b (unsigned).
// No state, no latency.
module comparator_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq,
  output logic       gt,
  output logic       lt
);

  // Bit-level form so the cell maps directly onto a small gate tree.
  assign gt = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);
  assign lt = (~a[1] & b[1]) | (~(a[1] ^ b[1]) & ~a[0] & b[0]);
  assign eq = ~(a[1] ^ b[1]) & ~(a[0] ^ b[0]);

endmodule

// File: rtl/comparator.sv
// Registered magnitude comparator built from 2-bit cells; one-cycle latency.
// Accepts a new pair every cycle, no backpressure; flags hold while in_valid is low.
module comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             equal,
  output logic             greater,
  output logic             lesser,
  output logic             out_valid
);

  localparam int NCELL = WIDTH / CMP_CELL_W;

  logic [NCELL-1:0] cell_eq;
  logic [NCELL-1:0] cell_gt;
  logic [NCELL-1:0] cell_lt;

  for (genvar i = 0; i < NCELL; i++) begin : g_cell
    comparator_2bit u_cell (
      .a  (a[i*CMP_CELL_W +: CMP_CELL_W]),
      .b  (b[i*CMP_CELL_W +: CMP_CELL_W]),
      .eq (cell_eq[i]),
      .gt (cell_gt[i]),
      .lt (cell_lt[i])
    );
  end

  logic     gt_acc;
  logic     lt_acc;
  logic     c_gt;
  logic     c_lt;
  cmp_res_e res;

  // LSB-to-MSB fold is equivalent to an MSB-first priority merge.
  always_comb begin
    gt_acc = 1'b0;
    lt_acc = 1'b0;
    c_gt   = 1'b0;
    c_lt   = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      c_gt = cell_gt[i];
      c_lt = cell_lt[i];
      // Differing sign bits invert the order decided by the top cell.
      if (SIGNED && (i == NCELL - 1) && (a[WIDTH-1] ^ b[WIDTH-1])) begin
        c_gt = cell_lt[i];
        c_lt = cell_gt[i];
      end
      gt_acc = c_gt | (cell_eq[i] & gt_acc);
      lt_acc = c_lt | (cell_eq[i] & lt_acc);
    end
    if (&cell_eq)
      res = CMP_EQ;
    else if (gt_acc)
      res = CMP_GT;
    else
      res = CMP_LT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      equal     <= 1'b0;
      greater   <= 1'b0;
      lesser    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        equal   <= (res == CMP_EQ);
        greater <= (res == CMP_GT);
        lesser  <= (res == CMP_LT);
      end
    end
  end

endmodule

// File: tb/tb_comparator.sv
// Directed bench: unsigned and signed comparator instances driven in parallel.
module tb_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;

  logic u_eq, u_gt, u_lt, u_vld;
  logic s_eq, s_gt, s_lt, s_vld;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  comparator #(.WIDTH(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .equal(u_eq), .greater(u_gt), .lesser(u_lt), .out_valid(u_vld)
  );

  comparator #(.WIDTH(4), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .equal(s_eq), .greater(s_gt), .lesser(s_lt), .out_valid(s_vld)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sgn;
    logic [2:0] exp;  // {eq, gt, lt}
  } vec_t;

  vec_t vecs[12];

  // Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares {out_valid, eq, gt, lt}.
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got vld/eq/gt/lt=%b expected %b (a=%0d b=%0d)", name, act, exp, a, b);
    end
  endtask

  task automatic apply(input logic [3:0] va, input logic [3:0] vb);
    rst      = 1'b0;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    step();
  endtask

  logic signed [3:0] sa, sb;

  initial begin
    vecs[0]  = '{4'd0,  4'd0,  1'b0, 3'b100};
    vecs[1]  = '{4'd15, 4'd0,  1'b0, 3'b010};
    vecs[2]  = '{4'd0,  4'd15, 1'b0, 3'b001};
    vecs[3]  = '{4'b1000, 4'b0111, 1'b1, 3'b001};  // -8 vs +7
    vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 3'b001};  // -1 vs 0
    vecs[5]  = '{4'b0001, 4'b1111, 1'b1, 3'b010};  // +1 vs -1
    vecs[6]  = '{4'b1000, 4'b0111, 1'b0, 3'b010};  // 8 vs 7 unsigned
    vecs[7]  = '{4'b0111, 4'b1000, 1'b1, 3'b010};  // +7 vs -8
    vecs[8]  = '{4'd14, 4'd13, 1'b1, 3'b010};      // -2 vs -3
    vecs[9]  = '{4'd13, 4'd14, 1'b1, 3'b001};      // -3 vs -2
    vecs[10] = '{4'd6,  4'd10, 1'b1, 3'b010};      // +6 vs -6
    vecs[11] = '{4'd6,  4'd10, 1'b0, 3'b001};

    // Reset held two cycles with a valid pair present.
    rst = 1'b1; in_valid = 1'b1; a = 4'd5; b = 4'd3;
    step();
    chk("reset_c1_u", {u_vld, u_eq, u_gt, u_lt}, 4'b0000);
    chk("reset_c1_s", {s_vld, s_eq, s_gt, s_lt}, 4'b0000);
    step();
    chk("reset_c2_u", {u_vld, u_eq, u_gt, u_lt}, 4'b0000);
    chk("reset_c2_s", {s_vld, s_eq, s_gt, s_lt}, 4'b0000);

    // Boundary vector table.
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b);
      if (vecs[i].sgn)
        chk($sformatf("vec%0d_s", i), {s_vld, s_eq, s_gt, s_lt}, {1'b1, vecs[i].exp});
      else
        chk($sformatf("vec%0d_u", i), {u_vld, u_eq, u_gt, u_lt}, {1'b1, vecs[i].exp});
    end

    // Exhaustive sweep, one pair per cycle with no gaps.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        sa = 4'(i);
        sb = 4'(j);
        apply(4'(i), 4'(j));
        chk("exh_u", {u_vld, u_eq, u_gt, u_lt}, {1'b1, i == j, i > j, i < j});
        chk("exh_s", {s_vld, s_eq, s_gt, s_lt}, {1'b1, sa == sb, sa > sb, sa < sb});
      end
    end

    // Hold: flags keep the last result while in_valid is low.
    apply(4'd9, 4'd9);
    chk("hold_load", {u_vld, u_eq, u_gt, u_lt}, 4'b1100);
    in_valid = 1'b0; a = 4'd1; b = 4'd2;
    step();
    chk("hold_c1", {u_vld, u_eq, u_gt, u_lt}, 4'b0100);
    step();
    chk("hold_c2", {s_vld, s_eq, s_gt, s_lt}, 4'b0100);

    // Back-to-back results with no bubbles.
    apply(4'd3, 4'd3);
    chk("b2b_eq", {u_vld, u_eq, u_gt, u_lt}, 4'b1100);
    apply(4'd7, 4'd2);
    chk("b2b_gt", {u_vld, u_eq, u_gt, u_lt}, 4'b1010);
    apply(4'd2, 4'd7);
    chk("b2b_lt", {u_vld, u_eq, u_gt, u_lt}, 4'b1001);

    // Reset coincident with a valid sample discards it.
    rst = 1'b1; in_valid = 1'b1; a = 4'd12; b = 4'd4;
    step();
    chk("midrst_u", {u_vld, u_eq, u_gt, u_lt}, 4'b0000);
    chk("midrst_s", {s_vld, s_eq, s_gt, s_lt}, 4'b0000);
    apply(4'd12, 4'd4);
    chk("post_rst_u", {u_vld, u_eq, u_gt, u_lt}, 4'b1010);
    chk("post_rst_s", {s_vld, s_eq, s_gt, s_lt}, 4'b1001);  // -4 vs +4

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
